wb_pipe_monitor: RTL and testbench
==================================

Name: wb_pipe_monitor

Overview:
Synthesizable protocol monitor for Wishbone B4 pipelined buses. It is the next-generation checker: it tracks multiple outstanding transactions, supports ERR/RTY terminations and response-latency timeouts, and reports violations on registered outputs. It is bound passively to any master/slave link, in simulation or in FPGA debug builds, and drives no bus signal.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width; SEL_W = DAT_W/8
MAX_OUTST, 4, max accepted-but-unanswered requests (1..255)
TIMEOUT, 16, max cycles with outstanding>0 and no response (1..65535)
CNT_W, 8, violation counter width
RULE_EN, 7'h7F, per-rule enable mask (bit index = rule code)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cyc  in  1  bus CYC
stb  in  1  bus STB
we  in  1  bus WE
sel  in  SEL_W  bus SEL
adr  in  ADR_W  bus ADR
dat_m  in  DAT_W  master write data
stall  in  1  slave STALL
ack  in  1  slave ACK
err  in  1  slave ERR
rty  in  1  slave RTY
clear  in  1  synchronous clear of sticky/count/first state
viol  out  7  per-rule violation pulse, registered
viol_sticky  out  7  OR of all pulses since reset/clear
viol_cnt  out  CNT_W  total violation cycles, saturating
first_code  out  3  rule code of first violation; valid when any sticky bit is set
outst  out  8  current outstanding count

Behaviour:
- Reset: all outputs, including outst and internal timers, are 0.
- Definitions: accept = cyc&stb&!stall; resp = ack|err|rty.
- Outstanding count:
  - next = outst + accept - resp.
  - resp with outst==0 is rule 0 and does not decrement.
  - accept with outst==MAX_OUTST and no resp is rule 3; outst saturates.
  - cyc==0 forces next=0.
  - A response never retires a request accepted in the same cycle (zero-latency ACK to a same-cycle accept is rule 0 when outst==0).
- Rules (code: condition, evaluated in cycle t):
  - 0 RESP_NO_REQ: resp && outst==0
  - 1 MULTI_RESP: more than one of ack/err/rty high
  - 2 TIMEOUT: timer reaches TIMEOUT. The timer counts cycles with outst>0 && !resp and clears on resp or outst==0. The rule fires once, then the timer holds until cleared.
  - 3 OVERFLOW: as above
  - 4 STALL_CHANGE: cycle t-1 had cyc&stb&stall, and cycle t has any of: !stb, !cyc, adr/we/sel changed, or (we && dat_m changed)
  - 5 CYC_DROP: !cyc && outst>0
  - 6 STB_NO_CYC: stb && !cyc
- Reporting:
  - viol[i] = rule i fired in cycle t & RULE_EN[i], registered: visible at edge t+1, held for one cycle.
  - viol_sticky |= viol.
  - viol_cnt increments by 1 per cycle with any viol bit set, saturating at all-ones.
  - first_code latches the lowest set code on the first violating cycle after reset/clear.
- clear: zeroes viol_sticky, viol_cnt and first_code next edge. A violation in the same cycle as clear is recorded after the clear (it wins). clear does not affect outst or the timer.
- Reset mid-transaction discards all tracking. No violation is reported for responses in flight at reset.
- The monitor is purely observational; no combinational path from inputs to outputs.

Decomposition:
- Package wb_mon_pkg: rule code enum (RESP_NO_REQ..STB_NO_CYC), NUM_RULES=7, rule mask constants.
- Sub-module wb_mon_stall_hold: registers the stalled request (adr/we/sel/dat_m/valid) and produces the rule-4 flag.
- Outstanding counter, timer and reporting logic stay in the top module.

Test Plan:
- Four back-to-back accepts, ACKs at latency 3 -> outst goes 1,2,3,4 then back to 0; viol stays 0.
- MAX_OUTST=4, five accepts before any ACK -> viol[3] pulses one cycle after the 5th accept; outst stays 4.
- TIMEOUT=16, one accept then no response -> viol[2] pulses exactly once, at edge 17 after the accept.
- Stalled request, adr changes 0x100->0x104 while stall=1 -> viol[4] pulses; first_code=4; viol_cnt=1.
- ACK with cyc=1, outst=0; next cycle ack&err together -> viol[0] then viol[1]; sticky=7'b0000011; first_code=0.
- cyc dropped with outst=2, then clear pulsed -> viol[5] pulses, outst=0; after clear, sticky=0 and cnt=0.

Source files
------------

// File: rtl/wb_mon_pkg.sv
// wb_mon_pkg
// Shared definitions for the Wishbone B4 pipelined protocol monitor:
// the rule-code enumeration, the number of rules, per-rule mask constants
// and a helper that picks the lowest-numbered rule from a violation vector.
package wb_mon_pkg;

  localparam int NUM_RULES = 7;

  typedef enum logic [2:0] {
    RESP_NO_REQ  = 3'd0,
    MULTI_RESP   = 3'd1,
    TIMEOUT_HIT  = 3'd2,
    OVERFLOW     = 3'd3,
    STALL_CHANGE = 3'd4,
    CYC_DROP     = 3'd5,
    STB_NO_CYC   = 3'd6
  } rule_code_e;

  localparam logic [NUM_RULES-1:0] MASK_RESP_NO_REQ  = 7'b000_0001;
  localparam logic [NUM_RULES-1:0] MASK_MULTI_RESP   = 7'b000_0010;
  localparam logic [NUM_RULES-1:0] MASK_TIMEOUT      = 7'b000_0100;
  localparam logic [NUM_RULES-1:0] MASK_OVERFLOW     = 7'b000_1000;
  localparam logic [NUM_RULES-1:0] MASK_STALL_CHANGE = 7'b001_0000;
  localparam logic [NUM_RULES-1:0] MASK_CYC_DROP     = 7'b010_0000;
  localparam logic [NUM_RULES-1:0] MASK_STB_NO_CYC   = 7'b100_0000;
  localparam logic [NUM_RULES-1:0] MASK_ALL          = 7'b111_1111;

  // Lowest set rule code; scanning from the top down lets the lowest win.
  function automatic logic [2:0] lowest_code(input logic [NUM_RULES-1:0] v);
    logic [2:0] code;
    code = 3'd0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (v[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/wb_mon_stall_hold.sv
// wb_mon_stall_hold
// Remembers the request that was presented while the slave stalled and
// flags when the master changes it (or withdraws it) in the next cycle.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cyc, stb, we, sel,
//   adr, dat_m, stall     observed bus signals
//   stall_change          rule-4 condition for the current cycle (comb)
module wb_mon_stall_hold
  import wb_mon_pkg::*;
#(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cyc,
  input  logic               stb,
  input  logic               we,
  input  logic [DAT_W/8-1:0] sel,
  input  logic [ADR_W-1:0]   adr,
  input  logic [DAT_W-1:0]   dat_m,
  input  logic               stall,
  output logic               stall_change
);

  logic               valid_q, valid_d;
  logic               we_q, we_d;
  logic [DAT_W/8-1:0] sel_q, sel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;

  // Snapshot the request every cycle; valid marks that it was stalled and
  // therefore must be held unchanged in the following cycle.
  always_comb begin
    valid_d = cyc & stb & stall;
    we_d    = we;
    sel_d   = sel;
    adr_d   = adr;
    dat_d   = dat_m;
  end

  // Snapshot registers; reset clears any pending stalled request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Write data only matters when the held request is a write.
  always_comb begin
    stall_change = 1'b0;
    if (valid_q) begin
      stall_change = !stb || !cyc || (adr != adr_q) || (we != we_q) ||
                     (sel != sel_q) || (we && (dat_m != dat_q));
    end
  end

endmodule

// File: rtl/wb_pipe_monitor.sv
// wb_pipe_monitor
// Passive Wishbone B4 pipelined protocol checker. Tracks outstanding
// requests, response latency and request stability under stall, and
// reports rule violations on registered outputs. Drives no bus signal.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cyc..rty            observed bus signals
//   clear               synchronous clear of sticky, count and first code
//   viol                per-rule violation pulse (one cycle)
//   viol_sticky         OR of all pulses since reset/clear
//   viol_cnt            saturating count of violating cycles
//   first_code          rule code of the first violation
//   outst               current outstanding request count
module wb_pipe_monitor
  import wb_mon_pkg::*;
#(
  parameter int               ADR_W     = 32,
  parameter int               DAT_W     = 32,
  parameter int               MAX_OUTST = 4,
  parameter int               TIMEOUT   = 16,
  parameter int               CNT_W     = 8,
  parameter logic [NUM_RULES-1:0] RULE_EN = 7'h7F
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cyc,
  input  logic               stb,
  input  logic               we,
  input  logic [DAT_W/8-1:0] sel,
  input  logic [ADR_W-1:0]   adr,
  input  logic [DAT_W-1:0]   dat_m,
  input  logic               stall,
  input  logic               ack,
  input  logic               err,
  input  logic               rty,
  input  logic               clear,
  output logic [6:0]         viol,
  output logic [6:0]         viol_sticky,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic [2:0]         first_code,
  output logic [7:0]         outst
);

  localparam logic [7:0]  MAX_V      = 8'(MAX_OUTST);
  localparam logic [15:0] TIMEOUT_V  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  logic accept, resp, retire, stall_change;
  logic [NUM_RULES-1:0] fired;

  logic [7:0]           outst_q, outst_d;
  logic [15:0]          timer_q, timer_d;
  logic [NUM_RULES-1:0] viol_q, viol_d;
  logic [NUM_RULES-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           first_q, first_d;

  wb_mon_stall_hold #(
    .ADR_W (ADR_W),
    .DAT_W (DAT_W)
  ) u_stall_hold (
    .clk          (clk),
    .reset_n      (reset_n),
    .cyc          (cyc),
    .stb          (stb),
    .we           (we),
    .sel          (sel),
    .adr          (adr),
    .dat_m        (dat_m),
    .stall        (stall),
    .stall_change (stall_change)
  );

  // Handshake decode. A response only retires something already
  // outstanding, never the request accepted in the same cycle.
  always_comb begin
    accept = cyc & stb & ~stall;
    resp   = ack | err | rty;
    retire = resp && (outst_q != 8'd0);
  end

  // Outstanding count saturates at MAX_OUTST; dropping cyc abandons
  // everything in flight.
  always_comb begin
    outst_d = outst_q;
    if (!cyc) begin
      outst_d = 8'd0;
    end else begin
      case ({accept, retire})
        2'b10:   if (outst_q != MAX_V) outst_d = outst_q + 8'd1;
        2'b01:   outst_d = outst_q - 8'd1;
        default: outst_d = outst_q;
      endcase
    end
  end

  // Response-latency timer: stops at TIMEOUT so the rule fires only once
  // per silent stretch, and restarts on any response or when idle.
  always_comb begin
    timer_d = timer_q;
    if ((outst_q == 8'd0) || resp) begin
      timer_d = 16'd0;
    end else if (timer_q != TIMEOUT_V) begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Rule conditions for the current cycle, indexed by rule code.
  always_comb begin
    fired = '0;
    fired[RESP_NO_REQ]  = resp && (outst_q == 8'd0);
    fired[MULTI_RESP]   = (ack & err) | (ack & rty) | (err & rty);
    fired[TIMEOUT_HIT]  = (outst_q != 8'd0) && !resp && (timer_q == TIMEOUT_M1);
    fired[OVERFLOW]     = accept && !resp && (outst_q == MAX_V);
    fired[STALL_CHANGE] = stall_change;
    fired[CYC_DROP]     = !cyc && (outst_q != 8'd0);
    fired[STB_NO_CYC]   = stb && !cyc;
  end

  // Reporting state. Sticky, count and first code are fed from the same
  // masked vector as the pulse so they all update on the same edge. On a
  // clear the history restarts from this cycle's violations, so a
  // violation coinciding with clear survives it.
  always_comb begin
    viol_d   = fired & RULE_EN;
    sticky_d = sticky_q | viol_d;
    cnt_d    = cnt_q;
    first_d  = first_q;
    if (clear) begin
      sticky_d = viol_d;
      cnt_d    = (viol_d != '0) ? CNT_W'(1) : '0;
      first_d  = (viol_d != '0) ? lowest_code(viol_d) : 3'd0;
    end else begin
      if ((viol_d != '0) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if ((viol_d != '0) && (sticky_q == '0)) first_d = lowest_code(viol_d);
    end
  end

  // All tracking and reporting state; reset discards transactions in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outst_q  <= 8'd0;
      timer_q  <= 16'd0;
      viol_q   <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      first_q  <= 3'd0;
    end else begin
      outst_q  <= outst_d;
      timer_q  <= timer_d;
      viol_q   <= viol_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  // Every output comes straight from a flop.
  always_comb begin
    viol        = viol_q;
    viol_sticky = sticky_q;
    viol_cnt    = cnt_q;
    first_code  = first_q;
    outst       = outst_q;
  end

endmodule

// File: tb/tb_wb_pipe_monitor.sv
// tb_wb_pipe_monitor
// Directed-vector bench for wb_pipe_monitor with default parameters
// (MAX_OUTST=4, TIMEOUT=16, CNT_W=8). Each stimulus step holds the bus
// for one cycle and outputs are sampled 1 time unit after the edge that
// closes that cycle.
module tb_wb_pipe_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we, stall, ack, err, rty, clear;
  logic [3:0]  sel;
  logic [31:0] adr, dat_m;
  logic [6:0]  viol, viol_sticky;
  logic [7:0]  viol_cnt, outst;
  logic [2:0]  first_code;

  int total_checks = 0;
  int bad_checks   = 0;
  logic [6:0] seen;

  wb_pipe_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cyc         (cyc),
    .stb         (stb),
    .we          (we),
    .sel         (sel),
    .adr         (adr),
    .dat_m       (dat_m),
    .stall       (stall),
    .ack         (ack),
    .err         (err),
    .rty         (rty),
    .clear       (clear),
    .viol        (viol),
    .viol_sticky (viol_sticky),
    .viol_cnt    (viol_cnt),
    .first_code  (first_code),
    .outst       (outst)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=0x%0h required=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle, then step past the edge that closes it.
  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [31:0] a, input logic st,
                               input logic ak, input logic er, input logic ry,
                               input logic cl);
    cyc = c; stb = s; we = w; adr = a; stall = st;
    ack = ak; err = er; rty = ry; clear = cl;
    sel = 4'hF; dat_m = 32'hA5A5_0000 ^ a;
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulseClear();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    cyc = 0; stb = 0; we = 0; stall = 0; ack = 0; err = 0; rty = 0; clear = 0;
    sel = 4'h0; adr = 32'h0; dat_m = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_viol", 32'(viol), 32'h0);
    checkOutput("reset_sticky", 32'(viol_sticky), 32'h0);
    checkOutput("reset_cnt", 32'(viol_cnt), 32'h0);
    checkOutput("reset_first", 32'(first_code), 32'h0);
    checkOutput("reset_outst", 32'(outst), 32'h0);
    reset_n = 1'b1;
    idleBus();

    // Four back-to-back accepts, then four ACKs: outst 1,2,3,4,3,2,1,0.
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 32'h200 + 32'(4 * i), 0, 0, 0, 0, 0);
      seen |= viol;
      checkOutput("b2b_outst_up", 32'(outst), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
      seen |= viol;
      checkOutput("b2b_outst_down", 32'(outst), 32'(3 - i));
    end
    idleBus();
    seen |= viol;
    checkOutput("b2b_no_viol", 32'(seen), 32'h0);
    checkOutput("b2b_sticky", 32'(viol_sticky), 32'h0);

    // Five accepts with no response: the fifth overflows.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0);
    checkOutput("ovf_quiet", 32'(viol), 32'h0);
    applyStimulus(1, 1, 0, 32'h310, 0, 0, 0, 0, 0);
    checkOutput("ovf_viol", 32'(viol), 32'h08);
    checkOutput("ovf_outst_sat", 32'(outst), 32'h4);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("ovf_pulse_once", 32'(viol), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("ovf_drained", 32'(outst), 32'h0);
    idleBus();
    pulseClear();
    checkOutput("ovf_clear_sticky", 32'(viol_sticky), 32'h0);
    checkOutput("ovf_clear_cnt", 32'(viol_cnt), 32'h0);

    // One accept then silence: timeout visible at edge 17 after the accept.
    applyStimulus(1, 1, 0, 32'h400, 0, 0, 0, 0, 0);
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
      seen |= viol;
    end
    checkOutput("tmo_early", 32'(seen), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("tmo_viol", 32'(viol), 32'h04);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
      seen |= viol;
    end
    checkOutput("tmo_once", 32'(seen), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("tmo_ack_outst", 32'(outst), 32'h0);
    idleBus();
    pulseClear();

    // Stalled request whose address moves 0x100 -> 0x104.
    applyStimulus(1, 1, 0, 32'h100, 1, 0, 0, 0, 0);
    checkOutput("stall_quiet", 32'(viol), 32'h0);
    applyStimulus(1, 1, 0, 32'h104, 1, 0, 0, 0, 0);
    checkOutput("stall_viol", 32'(viol), 32'h10);
    checkOutput("stall_first", 32'(first_code), 32'h4);
    checkOutput("stall_cnt", 32'(viol_cnt), 32'h1);
    applyStimulus(1, 1, 0, 32'h104, 0, 0, 0, 0, 0);
    checkOutput("stall_held_ok", 32'(viol), 32'h0);
    checkOutput("stall_accept", 32'(outst), 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    idleBus();
    pulseClear();

    // Unsolicited ACK, then ACK+ERR with nothing outstanding.
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 0, 0);
    checkOutput("resp_no_req", 32'(viol), 32'h01);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 1, 0, 0);
    checkOutput("multi_resp", 32'(viol), 32'h03);
    checkOutput("resp_sticky", 32'(viol_sticky), 32'h03);
    checkOutput("resp_first", 32'(first_code), 32'h0);
    checkOutput("resp_cnt", 32'(viol_cnt), 32'h2);
    idleBus();
    pulseClear();

    // cyc dropped with two outstanding.
    applyStimulus(1, 1, 0, 32'h500, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h504, 0, 0, 0, 0, 0);
    checkOutput("drop_outst_before", 32'(outst), 32'h2);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("drop_viol", 32'(viol), 32'h20);
    checkOutput("drop_outst", 32'(outst), 32'h0);
    checkOutput("drop_first", 32'(first_code), 32'h5);
    pulseClear();
    checkOutput("drop_clear_sticky", 32'(viol_sticky), 32'h0);
    checkOutput("drop_clear_cnt", 32'(viol_cnt), 32'h0);

    // Violation in the clear cycle survives the clear.
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 0, 1);
    checkOutput("clr_win_sticky", 32'(viol_sticky), 32'h40);
    checkOutput("clr_win_cnt", 32'(viol_cnt), 32'h1);
    checkOutput("clr_win_first", 32'(first_code), 32'h6);

    // Counter saturation: 260 more violating cycles.
    for (int i = 0; i < 260; i++) applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("cnt_saturate", 32'(viol_cnt), 32'hFF);
    idleBus();
    pulseClear();
    checkOutput("final_cnt", 32'(viol_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
